bcd_seg_display: RTL and testbench
==================================

Name: bcd_seg_display

Overview:
- Downstream consumer of the 8-bit up-counter value.
- Converts the binary count to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display (active-low anodes and segments) at a fixed refresh rate derived from the 100 MHz board clock.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot (1 kHz per digit at 100 MHz); benches use 4.
- BLANK_LZ, 1, 1 = blank leading zeros of hundreds/tens, 0 = always show three digits.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-high reset.
- cnt  input  8  binary count from the up-counter (unsigned, 0..255).
- an  output  4  digit anodes, active-low; an[0] = ones, an[1] = tens, an[2] = hundreds, an[3] = unused.
- seg  output  7  segments, active-low; seg[6] = a ... seg[0] = g.
- dp  output  1  decimal point, active-low; held 1 (off).
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, last_cnt = 0, disp_reg (12-bit BCD) = 0, shift/iter regs = 0.
  - refresh counter = 0, digit index = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1, busy = 0.
- Conversion FSM, states IDLE, CONVERT, LOAD:
  - IDLE: if cnt != last_cnt, capture cnt into an 8-bit shift reg, clear the 12-bit BCD accumulator and iteration count, then go to CONVERT. Otherwise stay.
  - CONVERT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, shift} left 1. Iteration count runs 0..7. After the 8th shift go to LOAD.
  - LOAD: disp_reg <= bcd; last_cnt <= captured value; go to IDLE.
  - busy = 1 in CONVERT and LOAD, 0 in IDLE (registered with state).
  - Latency: cnt change sampled at edge N -> disp_reg updated at edge N+9 (1 capture + 8 shifts; LOAD writes at edge N+9, state back to IDLE).
  - cnt changing during CONVERT/LOAD is ignored for the current conversion. The next IDLE cycle sees the mismatch and restarts; no value is lost except intermediate ones.
  - Reset value last_cnt = 0 matches disp_reg = 0, so cnt = 0 after reset triggers no conversion.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1, then wraps.
  - At the terminal count, the digit index increments 0 -> 1 -> 2 -> 3 -> 0.
  - an and seg are registered; they reflect the new index one cycle after the index change.
  - The selected digit drives an = ~(4'b0001 << idx).
  - Slot 3 always blank: an = 4'b1111, seg = 7'h7F. It keeps each digit's duty cycle at 1/4.
- Leading-zero blanking (BLANK_LZ = 1):
  - Hundreds is blank when its digit = 0.
  - Tens is blank when hundreds = 0 and tens = 0.
  - Ones is never blank.
  - A blank slot drives an = 4'b1111, seg = 7'h7F.
- Segment codes (active-low, a..g): 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04. Any non-BCD nibble decodes to 7F (unreachable; defensive).
- Display source is always disp_reg, never the in-flight accumulator. No glitch digit appears mid-conversion.

Test Plan:
- Reset: assert rst between clock edges -> an = 1111, seg = 1111111, dp = 1, busy = 0 immediately. Hold cnt = 0, release -> busy stays 0; slot 0 shows seg = 01, slots 1–2 blank (BLANK_LZ = 1).
- Full-scale conversion: REFRESH_DIV = 4, cnt 0 -> 255 -> busy high for exactly 9 cycles, then disp_reg = 12'h255. Scan shows slot0 seg = 24, slot1 seg = 24, slot2 seg = 12, slot3 an = 1111.
- Leading zeros: cnt = 7 -> slot0 seg = 0F; slots 1, 2 an = 1111. Rerun with BLANK_LZ = 0 -> slot1 and slot2 seg = 01 with anodes active. cnt = 105 -> tens slot shows 01 (middle zero is not blanked).
- Mid-conversion change: cnt = 100, then cnt = 42 on the 3rd CONVERT cycle -> disp_reg = 12'h100 after the first conversion. A second conversion starts the next cycle; disp_reg = 12'h042 after 9 more cycles; final display "42".
- Async reset mid-conversion: assert rst during CONVERT -> all outputs return to reset values immediately and state = IDLE. After release with cnt = 200 -> a new conversion completes with disp_reg = 12'h200.
- Integration sweep: drive cnt from the up-counter (En = 1, 100 MHz) through 255 -> 0 wrap; slow cnt to one step per 16 clocks. After each busy fall, disp_reg equals the BCD of cnt for every value 0..255.

Source files
------------

// File: rtl/bcd_seg_display.sv
// rtl/bcd_seg_display.sv - binary count to BCD with multiplexed 4-digit seven-segment scan
module bcd_seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cnt,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RC_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t      state;
  logic [7:0]  last_cnt;
  logic [7:0]  cap;
  logic [7:0]  shift_reg;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  iter;
  logic [11:0] disp_reg;

  logic [RW-1:0] rc;
  logic [1:0]    idx;

  logic [3:0] nib;
  logic       blank;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h01;
      4'd1:    return 7'h4F;
      4'd2:    return 7'h12;
      4'd3:    return 7'h06;
      4'd4:    return 7'h4C;
      4'd5:    return 7'h24;
      4'd6:    return 7'h20;
      4'd7:    return 7'h0F;
      4'd8:    return 7'h00;
      4'd9:    return 7'h04;
      default: return 7'h7F;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble that is 5 or more, applied before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture on change, eight shift-add-3 steps, then publish to disp_reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_cnt  <= 8'd0;
      cap       <= 8'd0;
      shift_reg <= 8'd0;
      bcd       <= 12'd0;
      iter      <= 3'd0;
      disp_reg  <= 12'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt != last_cnt) begin
            cap       <= cnt;
            shift_reg <= cnt;
            bcd       <= 12'd0;
            iter      <= 3'd0;
            state     <= CONVERT;
            busy      <= 1'b1;
          end
        end
        CONVERT: begin
          {bcd, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
          iter             <= iter + 3'd1;
          if (iter == 3'd7) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          disp_reg <= bcd;
          last_cnt <= cap;
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Refresh prescaler and digit slot index; slot 3 is a blank slot for 1/4 duty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc  <= '0;
      idx <= 2'd0;
    end else if (rc == RC_LAST) begin
      rc  <= '0;
      idx <= idx + 2'd1;
    end else begin
      rc <= rc + RW'(1);
    end
  end

  // Select the digit for the current slot and apply leading-zero blanking
  always_comb begin
    nib   = 4'd0;
    blank = 1'b1;
    case (idx)
      2'd0: begin
        nib   = disp_reg[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = disp_reg[7:4];
        blank = BLANK_LZ && (disp_reg[11:8] == 4'd0) && (disp_reg[7:4] == 4'd0);
      end
      2'd2: begin
        nib   = disp_reg[11:8];
        blank = BLANK_LZ && (disp_reg[11:8] == 4'd0);
      end
      default: begin
        nib   = 4'd0;
        blank = 1'b1;
      end
    endcase
    an_next  = blank ? 4'b1111 : ~(4'b0001 << idx);
    seg_next = blank ? 7'h7F : seg_decode(nib);
  end

  // Registered anode and segment drive, one cycle behind the slot index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_seg_display.sv
// tb/tb_bcd_seg_display.sv - scoreboard bench for bcd_seg_display
module tb_bcd_seg_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cnt = 8'd0;
  logic [3:0] an_lz, an_nz;
  logic [6:0] seg_lz, seg_nz;
  logic       dp_lz, dp_nz, busy_lz, busy_nz;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_active = 1'b0;

  typedef struct {
    logic [11:0] bcd;
    bit          show;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_lz (
    .clk(clk), .rst(rst), .cnt(cnt), .an(an_lz), .seg(seg_lz), .dp(dp_lz), .busy(busy_lz)
  );

  bcd_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_nz (
    .clk(clk), .rst(rst), .cnt(cnt), .an(an_nz), .seg(seg_nz), .dp(dp_nz), .busy(busy_nz)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h01;  4'd1: return 7'h4F;  4'd2: return 7'h12;
      4'd3: return 7'h06;  4'd4: return 7'h4C;  4'd5: return 7'h24;
      4'd6: return 7'h20;  4'd7: return 7'h0F;  4'd8: return 7'h00;
      4'd9: return 7'h04;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // {visible, seg} expected for digit slot d
  function automatic logic [7:0] exp_slot(input logic [11:0] b, input bit blz, input int d);
    logic [3:0] h, t, o;
    h = b[11:8]; t = b[7:4]; o = b[3:0];
    case (d)
      0: return {1'b1, seg_of(o)};
      1: return (blz && h == 4'd0 && t == 4'd0) ? {1'b0, 7'h7F} : {1'b1, seg_of(t)};
      2: return (blz && h == 4'd0) ? {1'b0, 7'h7F} : {1'b1, seg_of(h)};
      default: return {1'b0, 7'h7F};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample_inst(input logic [3:0] a, input logic [6:0] s, input logic [11:0] b,
                             input bit blz, inout int bad, inout logic [2:0] seen);
    logic [3:0] pat;
    logic [7:0] ex;
    bit         found;
    if (a == 4'b1111) begin
      if (s != 7'h7F) bad++;
    end else begin
      found = 1'b0;
      for (int d = 0; d < 3; d++) begin
        pat = ~(4'b0001 << d);
        if (a == pat) begin
          found   = 1'b1;
          seen[d] = 1'b1;
          ex      = exp_slot(b, blz, d);
          if (!ex[7] || s != ex[6:0]) bad++;
        end
      end
      if (!found) bad++;
    end
  endtask

  // Watches one full scan period on both instances and compares against the model
  task automatic check_display(input logic [11:0] b, input string tag);
    int         bad_lz, bad_nz;
    logic [2:0] seen_lz, seen_nz, vis_lz, vis_nz;
    logic [7:0] e0, e1, e2;
    bad_lz = 0; bad_nz = 0; seen_lz = 3'b000; seen_nz = 3'b000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sample_inst(an_lz, seg_lz, b, 1'b1, bad_lz, seen_lz);
      sample_inst(an_nz, seg_nz, b, 1'b0, bad_nz, seen_nz);
    end
    e0 = exp_slot(b, 1'b1, 0); e1 = exp_slot(b, 1'b1, 1); e2 = exp_slot(b, 1'b1, 2);
    vis_lz = {e2[7], e1[7], e0[7]};
    e0 = exp_slot(b, 1'b0, 0); e1 = exp_slot(b, 1'b0, 1); e2 = exp_slot(b, 1'b0, 2);
    vis_nz = {e2[7], e1[7], e0[7]};
    check({tag, " scan_lz_bad"}, 32'(bad_lz), 32'd0);
    check({tag, " scan_nz_bad"}, 32'(bad_nz), 32'd0);
    check({tag, " lit_lz"}, 32'(seen_lz), 32'(vis_lz));
    check({tag, " lit_nz"}, 32'(seen_nz), 32'(vis_nz));
  endtask

  // Monitor: on every busy fall, pop an expectation and check result and display
  initial begin
    int   run;
    logic prev, b;
    exp_t e;
    run = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run  = 0;
        prev = 1'b0;
      end else begin
        b = busy_lz;
        if (b) begin
          run++;
        end else if (prev) begin
          mon_active = 1'b1;
          if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check($sformatf("busy_len_%03h", e.bcd), 32'(run), 32'd9);
            check($sformatf("disp_lz_%03h", e.bcd), 32'(u_lz.disp_reg), 32'(e.bcd));
            check($sformatf("disp_nz_%03h", e.bcd), 32'(u_nz.disp_reg), 32'(e.bcd));
            if (e.show) check_display(e.bcd, $sformatf("val_%03h", e.bcd));
          end
          run = 0;
          mon_active = 1'b0;
        end
        prev = b;
      end
    end
  end

  task automatic push(input logic [11:0] b, input bit show);
    exp_t e;
    e.bcd  = b;
    e.show = show;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 400 && (sb.size() != 0 || mon_active); i++) @(posedge clk);
    if (sb.size() != 0 || mon_active) begin
      check({tag, " timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic apply(input int v, input bit show);
    @(negedge clk);
    cnt = 8'(v);
    push(to_bcd(v), show);
    wait_done($sformatf("cnt_%0d", v));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " lz_out"}, 32'({an_lz, seg_lz, dp_lz, busy_lz}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    check({tag, " nz_out"}, 32'({an_nz, seg_nz, dp_nz, busy_nz}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
  endtask

  initial begin
    int busy_seen;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_lz || busy_nz) busy_seen++;
    end
    check("zero_no_convert", 32'(busy_seen), 32'd0);
    check_display(12'h000, "zero");

    apply(255, 1'b1);
    apply(7, 1'b1);
    apply(105, 1'b1);

    @(negedge clk);
    cnt = 8'd100;
    push(12'h100, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cnt = 8'd42;
    push(12'h042, 1'b1);
    wait_done("mid_change");

    @(negedge clk);
    cnt = 8'd150;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_mid");
    check("reset_mid_state", 32'(u_lz.state), 32'd0);
    cnt = 8'd200;
    @(posedge clk);
    #2 rst = 1'b0;
    push(12'h200, 1'b1);
    wait_done("after_reset");

    for (int v = 1; v <= 256; v++) begin
      apply(v % 256, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
